// File: rtl/truth_table_sweep.sv
// Stimulus-and-capture sweep: drives {A,B,C,D} through all 16 codes and records F1/F2 truth tables.
// Optional expected-table comparator is built when TT_CHECK_EN is defined.
module truth_table_sweep #(
  parameter int          SETTLE = 2,
  parameter logic [15:0] EXP_F1 = 16'h0000,
  parameter logic [15:0] EXP_F2 = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        F1,
  input  logic        F2,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_f1,
  output logic [15:0] tt_f2,
  output logic [4:0]  ones_f1,
  output logic        pass
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  abcd_q, abcd_d;
  logic        busy_q, busy_d;
  logic [15:0] tt_f1_q, tt_f1_d;
  logic [15:0] tt_f2_q, tt_f2_d;
  logic [4:0]  ones_q, ones_d;
  logic        pass_q, pass_d;

`ifndef TT_CHECK_EN
  logic unused_exp;
  assign unused_exp = ^{EXP_F1, EXP_F2};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      abcd_q  <= 4'd0;
      busy_q  <= 1'b0;
      tt_f1_q <= 16'h0000;
      tt_f2_q <= 16'h0000;
      ones_q  <= 5'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      tt_f1_q <= tt_f1_d;
      tt_f2_q <= tt_f2_d;
      ones_q  <= ones_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    abcd_d  = abcd_q;
    busy_d  = busy_q;
    tt_f1_d = tt_f1_q;
    tt_f2_d = tt_f2_q;
    ones_d  = ones_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tt_f1_d = 16'h0000;
          tt_f2_d = 16'h0000;
          ones_d  = 5'd0;
          pass_d  = 1'b0;
          idx_d   = 4'd0;
          abcd_d  = 4'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_M1) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        tt_f1_d[idx_q] = F1;
        tt_f2_d[idx_q] = F2;
        ones_d         = ones_q + {4'd0, F1};
        // Termination is by compare on the last code; idx never wraps.
        if (idx_q == 4'hF) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          abcd_d  = idx_q + 4'd1;
          cnt_d   = 4'd0;
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
`ifdef TT_CHECK_EN
        pass_d = (tt_f1_q == EXP_F1) && (tt_f2_q == EXP_F2);
`else
        pass_d = 1'b0;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign A       = abcd_q[3];
  assign B       = abcd_q[2];
  assign C       = abcd_q[1];
  assign D       = abcd_q[0];
  assign busy    = busy_q;
  assign done    = (state_q == S_DONE);
  assign tt_f1   = tt_f1_q;
  assign tt_f2   = tt_f2_q;
  assign ones_f1 = ones_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Directed bench for truth_table_sweep: two instances (SETTLE=2 and SETTLE=1) driving an XOR/AND or constant function.
module tb_truth_table_sweep;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic mode0 = 1'b0, mode1 = 1'b0;
  logic sel_v = 1'b0;

  logic a0, b0, c0, d0, busy0, done0, pass0, f1_0, f2_0;
  logic a1, b1, c1, d1, busy1, done1, pass1, f1_1, f2_1;
  logic [15:0] tt1_0, tt2_0, tt1_1, tt2_1;
  logic [4:0]  ones0, ones1;
  logic cur_busy, cur_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Function under study: XOR of all inputs / A&B, or constant 1 / 0.
  assign f1_0 = mode0 ? 1'b1 : (a0 ^ b0 ^ c0 ^ d0);
  assign f2_0 = mode0 ? 1'b0 : (a0 & b0);
  assign f1_1 = mode1 ? 1'b1 : (a1 ^ b1 ^ c1 ^ d1);
  assign f2_1 = mode1 ? 1'b0 : (a1 & b1);
  assign cur_busy = sel_v ? busy1 : busy0;
  assign cur_done = sel_v ? done1 : done0;

  truth_table_sweep #(.SETTLE(2), .EXP_F1(16'h6996), .EXP_F2(16'hF000)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .F1(f1_0), .F2(f2_0),
    .A(a0), .B(b0), .C(c0), .D(d0), .busy(busy0), .done(done0),
    .tt_f1(tt1_0), .tt_f2(tt2_0), .ones_f1(ones0), .pass(pass0));

  truth_table_sweep #(.SETTLE(1), .EXP_F1(16'h6996), .EXP_F2(16'hF001)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .F1(f1_1), .F2(f2_1),
    .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1),
    .tt_f1(tt1_1), .tt_f2(tt2_1), .ones_f1(ones1), .pass(pass1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle k is the cycle following start-accept edge k-1; sampled #1 after each edge.
  task automatic run_sweep(input bit sel, input int pulse_at,
                           output int busy_n, output int done_at, output int done_n);
    sel_v = sel;
    @(posedge clk); #1;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    busy_n = 0; done_at = 0; done_n = 0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      if (cur_busy) busy_n++;
      if (cur_done) begin done_n++; done_at = cyc; end
      if (!sel) start0 = (cyc == pulse_at);
      @(posedge clk); #1;
    end
    start0 = 1'b0;
  endtask

  int bn, da, dn, idle_busy, abort_done;

  initial begin
    // Reset then idle
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy0 || busy1 || done0) idle_busy++;
    end
    chk("idle_busy", idle_busy, 0);
    chk("rst_abcd", {a0, b0, c0, d0}, 4'h0);
    chk("rst_tt", {tt1_0, tt2_0}, 32'h0);
    chk("rst_ones_pass", {ones0, pass0}, 6'h0);

    // XOR/AND sweep with a stray start at cycle 10
    run_sweep(1'b0, 10, bn, da, dn);
    chk("xor_busy_cycles", bn, 48);
    chk("xor_done_cycle", da, 49);
    chk("xor_done_count", dn, 1);
    chk("xor_tt_f1", tt1_0, 16'h6996);
    chk("xor_tt_f2", tt2_0, 16'hF000);
    chk("xor_ones", ones0, 5'd8);
    chk("xor_abcd_final", {a0, b0, c0, d0}, 4'hF);
`ifdef TT_CHECK_EN
    chk("xor_pass_match", pass0, 1'b1);
`else
    chk("xor_pass_off", pass0, 1'b0);
`endif

    // SETTLE=1 instance, expected F2 deliberately off by one bit
    run_sweep(1'b1, 0, bn, da, dn);
    chk("s1_busy_cycles", bn, 32);
    chk("s1_done_cycle", da, 33);
    chk("s1_tt_f1", tt1_1, 16'h6996);
    chk("s1_tt_f2", tt2_1, 16'hF000);
    chk("s1_pass_mismatch", pass1, 1'b0);

    // Abort at cycle 20
    sel_v = 1'b0;
    abort_done = 0;
    @(posedge clk); #1; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) begin
      if (done0) abort_done++;
      @(posedge clk); #1;
    end
    chk("mid_tt_f1", tt1_0, 16'h0016);
    chk("mid_ones", ones0, 5'd3);
    chk("mid_abcd", {a0, b0, c0, d0}, 4'h6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy_done", {busy0, done0}, 2'b00);
    chk("abort_tt", {tt1_0, tt2_0}, 32'h0);
    chk("abort_abcd_ones", {a0, b0, c0, d0, ones0, pass0}, 10'h0);
    for (int i = 0; i < 60; i++) begin
      if (done0 || busy0) abort_done++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", abort_done, 0);
    run_sweep(1'b0, 0, bn, da, dn);
    chk("post_abort_tt_f1", tt1_0, 16'h6996);
    chk("post_abort_done", da, 49);

    // Constant function
    mode0 = 1'b1;
    run_sweep(1'b0, 0, bn, da, dn);
    chk("const_tt_f1", tt1_0, 16'hFFFF);
    chk("const_ones", ones0, 5'b10000);
    chk("const_tt_f2", tt2_0, 16'h0000);
    chk("const_pass", pass0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
